mode_controller: RTL and testbench

Top-level sequencer for the digital alarm clock: owns the run/adjust/ring mode state machine and drives the enables of the time-of-day counter chain and the alarm register. Consumes single-cycle button pulses from the debouncers and the 1 Hz tick from the prescaler. Emits the seconds-chain enable, a clear pulse for the seconds counters, a digit-field select and increment/decrement pulses for the hours/minutes counters, plus blink and buzzer controls for the display and output stage.

---
 rtl/mode_controller_pkg.sv | 19 +
 rtl/mode_controller_ring_timer.sv | 41 ++++
 rtl/mode_controller.sv | 149 ++++++++++++++
 tb/tb_mode_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_controller_pkg.sv
// mode_controller_pkg
// Shared definitions for the alarm-clock mode sequencer: state encoding,
// digit-field select codes and the default ring duration.
package mode_controller_pkg;

  typedef enum logic [1:0] {
    ST_TIME = 2'd0,
    ST_ADJ  = 2'd1,
    ST_RING = 2'd2
  } state_e;

  localparam logic [1:0] SEL_CLK_H = 2'd0;
  localparam logic [1:0] SEL_CLK_M = 2'd1;
  localparam logic [1:0] SEL_ALM_H = 2'd2;
  localparam logic [1:0] SEL_ALM_M = 2'd3;

  localparam int RING_SECONDS_DEFAULT = 60;

endpackage

// File: rtl/mode_controller_ring_timer.sv
// ring_timer
// 8-bit tick counter that measures how long the buzzer has been sounding.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr_i     synchronous clear to zero (takes priority over en_i)
//   en_i      count one step
//   tc_o      high while the count sits one below LIMIT, so the LIMIT-th
//             enabled step is the one that sees tc_o asserted
module ring_timer #(
  parameter int LIMIT = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/mode_controller.sv
// mode_controller
// Run/adjust/ring sequencer for the digital alarm clock.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   tick_1hz                    one-cycle pulse per second
//   btnC/btnU/btnD/btnL/btnR    debounced one-cycle button pulses
//   alarm_match                 level, clock HH:MM equals alarm HH:MM
//   alarm_arm                   level, alarm may fire only when high
//   time_en                     seconds-chain enable (combinational)
//   sec_clr                     one-cycle clear of the seconds counters
//   adjust                      high in ADJ
//   sel                         field under adjust
//   inc_pulse, dec_pulse        one-cycle step for the selected field
//   blink                       blank phase for the selected field
//   buzzer_en                   high in RING
module mode_controller
  import mode_controller_pkg::*;
#(
  parameter int RING_SECONDS = RING_SECONDS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       alarm_match,
  input  logic       alarm_arm,
  output logic       time_en,
  output logic       sec_clr,
  output logic       adjust,
  output logic [1:0] sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       blink,
  output logic       buzzer_en
);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       blink_q, blink_d;
  logic       inc_q, inc_d;
  logic       dec_q, dec_d;
  logic       sec_clr_q, sec_clr_d;
  logic       match_q;
  logic       alarm_edge;
  logic       any_btn;
  logic       ring_tc;

  assign alarm_edge = alarm_match & ~match_q & alarm_arm;
  assign any_btn    = btnC | btnU | btnD | btnL | btnR;

  // Counter is held at zero outside RING, so each ring starts from zero.
  ring_timer #(
    .LIMIT (RING_SECONDS)
  ) u_ring_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != ST_RING),
    .en_i  (tick_1hz),
    .tc_o  (ring_tc)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    blink_d   = blink_q;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    sec_clr_d = 1'b0;

    case (state_q)
      ST_TIME: begin
        // btnC wins; a simultaneous alarm edge is lost because the
        // history register still records the high level this cycle.
        if (btnC) begin
          state_d = ST_ADJ;
          sel_d   = SEL_CLK_H;
          blink_d = 1'b1;
        end else if (alarm_edge) begin
          state_d = ST_RING;
        end
      end

      ST_ADJ: begin
        if (tick_1hz) begin
          blink_d = ~blink_q;
        end
        if (btnC) begin
          state_d   = ST_TIME;
          sec_clr_d = 1'b1;
        end else if (btnL || btnR) begin
          // L and R together cancel; U/D are ignored either way.
          if (btnR && !btnL) begin
            sel_d = sel_q + 2'd1;
          end else if (btnL && !btnR) begin
            sel_d = sel_q - 2'd1;
          end
        end else begin
          inc_d = btnU & ~btnD;
          dec_d = btnD & ~btnU;
        end
      end

      ST_RING: begin
        if (any_btn || !alarm_arm || (tick_1hz && ring_tc)) begin
          state_d = ST_TIME;
        end
      end

      default: begin
        state_d = ST_TIME;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_TIME;
      sel_q     <= SEL_CLK_H;
      blink_q   <= 1'b1;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      sec_clr_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      blink_q   <= blink_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      sec_clr_q <= sec_clr_d;
      match_q   <= alarm_match;
    end
  end

  // Seconds chain freezes while the user is adjusting.
  assign time_en   = tick_1hz & (state_q != ST_ADJ);
  assign sec_clr   = sec_clr_q;
  assign adjust    = (state_q == ST_ADJ);
  assign sel       = sel_q;
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
  assign blink     = blink_q;
  assign buzzer_en = (state_q == ST_RING);

endmodule

// File: tb/tb_mode_controller.sv
module tb_mode_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz, btnC, btnU, btnD, btnL, btnR;
  logic       alarm_match, alarm_arm;
  logic       time_en, sec_clr, adjust, inc_pulse, dec_pulse, blink, buzzer_en;
  logic [1:0] sel;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mode_controller dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .btnC        (btnC),
    .btnU        (btnU),
    .btnD        (btnD),
    .btnL        (btnL),
    .btnR        (btnR),
    .alarm_match (alarm_match),
    .alarm_arm   (alarm_arm),
    .time_en     (time_en),
    .sec_clr     (sec_clr),
    .adjust      (adjust),
    .sel         (sel),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .blink       (blink),
    .buzzer_en   (buzzer_en)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle button combination {C,U,D,L,R}, then release.
  task automatic press(input logic [4:0] b);
    {btnC, btnU, btnD, btnL, btnR} = b;
    cycle();
    {btnC, btnU, btnD, btnL, btnR} = 5'b0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cycle();
    tick_1hz = 1'b0;
  endtask

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  initial begin
    rst = 1'b1;
    tick_1hz = 0; btnC = 0; btnU = 0; btnD = 0; btnL = 0; btnR = 0;
    alarm_match = 0; alarm_arm = 0;
    cycle(); cycle();
    chk("rst_sel", {6'd0, sel}, 8'd0);
    chk("rst_blink", {7'd0, blink}, 8'd1);
    chk("rst_adjust", {7'd0, adjust}, 8'd0);
    chk("rst_buzzer", {7'd0, buzzer_en}, 8'd0);
    chk("rst_pulses", {5'd0, inc_pulse, dec_pulse, sec_clr}, 8'd0);
    rst = 1'b0;
    cycle();

    // Three ticks in TIME each pass straight through to time_en.
    for (int i = 0; i < 3; i++) begin
      tick_1hz = 1'b1;
      #1;
      chk($sformatf("time_en_run%0d", i), {7'd0, time_en}, 8'd1);
      cycle();
      tick_1hz = 1'b0;
      #1;
      chk($sformatf("time_en_idle%0d", i), {7'd0, time_en}, 8'd0);
    end
    chk("run_adjust", {7'd0, adjust}, 8'd0);
    chk("run_sel", {6'd0, sel}, 8'd0);
    chk("run_buzzer", {7'd0, buzzer_en}, 8'd0);

    // Enter ADJ, move to alarm hours, increment.
    press(B_C);
    chk("adj_enter", {7'd0, adjust}, 8'd1);
    chk("adj_sel0", {6'd0, sel}, 8'd0);
    chk("adj_blink", {7'd0, blink}, 8'd1);
    press(B_R);
    chk("sel_r1", {6'd0, sel}, 8'd1);
    press(B_R);
    chk("sel_r2", {6'd0, sel}, 8'd2);
    press(B_U);
    chk("inc_pulse", {7'd0, inc_pulse}, 8'd1);
    chk("inc_sel", {6'd0, sel}, 8'd2);
    cycle();
    chk("inc_one_cycle", {7'd0, inc_pulse}, 8'd0);

    // Ticks in ADJ: time frozen, blink toggles.
    tick_1hz = 1'b1;
    #1;
    chk("adj_time_en", {7'd0, time_en}, 8'd0);
    cycle();
    tick_1hz = 1'b0;
    chk("blink_t1", {7'd0, blink}, 8'd0);
    tick();
    chk("blink_t2", {7'd0, blink}, 8'd1);

    // Left wraps 0 -> 3; L+R cancels.
    press(B_L);
    chk("sel_l1", {6'd0, sel}, 8'd1);
    press(B_L);
    chk("sel_l0", {6'd0, sel}, 8'd0);
    press(B_L);
    chk("sel_wrap3", {6'd0, sel}, 8'd3);
    press(B_L | B_R);
    chk("sel_lr_hold", {6'd0, sel}, 8'd3);
    press(B_U | B_D);
    chk("ud_no_pulse", {6'd0, inc_pulse, dec_pulse}, 8'd0);
    press(B_D);
    chk("dec_pulse", {6'd0, inc_pulse, dec_pulse}, 8'd1);
    press(B_R | B_U);
    chk("r_over_u_sel", {6'd0, sel}, 8'd0);
    chk("r_over_u_inc", {7'd0, inc_pulse}, 8'd0);

    // Exit with C+U: no increment, one-cycle seconds clear.
    press(B_C | B_U);
    chk("exit_adjust", {7'd0, adjust}, 8'd0);
    chk("exit_sec_clr", {7'd0, sec_clr}, 8'd1);
    chk("exit_no_inc", {7'd0, inc_pulse}, 8'd0);
    cycle();
    chk("sec_clr_one", {7'd0, sec_clr}, 8'd0);

    // Armed alarm edge -> RING next cycle; 60 ticks -> silent.
    alarm_arm = 1'b1;
    cycle();
    alarm_match = 1'b1;
    cycle();
    chk("ring_start", {7'd0, buzzer_en}, 8'd1);
    tick_1hz = 1'b1;
    #1;
    chk("ring_time_en", {7'd0, time_en}, 8'd1);
    cycle();
    tick_1hz = 1'b0;
    cycle();
    for (int i = 2; i < 60; i++) begin
      tick();
      cycle();
    end
    chk("ring_59", {7'd0, buzzer_en}, 8'd1);
    tick();
    chk("ring_timeout", {7'd0, buzzer_en}, 8'd0);
    cycle(); cycle(); cycle();
    chk("no_retrigger", {7'd0, buzzer_en}, 8'd0);

    // New edge rings; btnD silences without a dec pulse.
    alarm_match = 1'b0;
    cycle();
    alarm_match = 1'b1;
    cycle();
    chk("ring2_start", {7'd0, buzzer_en}, 8'd1);
    press(B_D);
    chk("ring_btn_exit", {7'd0, buzzer_en}, 8'd0);
    chk("ring_btn_no_dec", {7'd0, dec_pulse}, 8'd0);
    chk("ring_btn_adjust", {7'd0, adjust}, 8'd0);

    // Edge during ADJ is ignored and not replayed on exit.
    alarm_match = 1'b0;
    press(B_C);
    alarm_match = 1'b1;
    cycle();
    chk("adj_edge_buzz", {7'd0, buzzer_en}, 8'd0);
    chk("adj_edge_adjust", {7'd0, adjust}, 8'd1);
    press(B_C);
    cycle();
    chk("adj_edge_lost", {7'd0, buzzer_en}, 8'd0);

    // btnC coincident with an alarm edge in TIME wins.
    alarm_match = 1'b0;
    cycle();
    alarm_match = 1'b1;
    press(B_C);
    chk("c_vs_edge_adj", {7'd0, adjust}, 8'd1);
    chk("c_vs_edge_buzz", {7'd0, buzzer_en}, 8'd0);
    press(B_C);

    // Disarming ends the ring.
    alarm_match = 1'b0;
    cycle();
    alarm_match = 1'b1;
    cycle();
    chk("ring3_start", {7'd0, buzzer_en}, 8'd1);
    alarm_arm = 1'b0;
    cycle();
    chk("disarm_exit", {7'd0, buzzer_en}, 8'd0);

    // Unarmed edge does nothing.
    alarm_match = 1'b0;
    cycle();
    alarm_match = 1'b1;
    cycle();
    chk("unarmed_edge", {7'd0, buzzer_en}, 8'd0);

    // Leave sel at 1, ring, then reset asynchronously mid-cycle.
    press(B_C);
    press(B_R);
    press(B_C);
    chk("pre_rst_sel", {6'd0, sel}, 8'd1);
    alarm_arm = 1'b1;
    alarm_match = 1'b0;
    cycle();
    alarm_match = 1'b1;
    cycle();
    chk("ring4_start", {7'd0, buzzer_en}, 8'd1);
    rst = 1'b1;
    #2;
    chk("async_buzzer", {7'd0, buzzer_en}, 8'd0);
    chk("async_sel", {6'd0, sel}, 8'd0);
    chk("async_adjust", {7'd0, adjust}, 8'd0);
    alarm_match = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    chk("post_rst_pulses", {5'd0, inc_pulse, dec_pulse, sec_clr}, 8'd0);
    chk("post_rst_buzzer", {7'd0, buzzer_en}, 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
